// File: rtl/aquarius_pad_pkg.sv
// rtl/aquarius_pad_pkg.sv - Aquarius hand-controller bit indices, code constants and encoder
package aquarius_pad_pkg;

  localparam int JOY_R  = 0;
  localparam int JOY_L  = 1;
  localparam int JOY_D  = 2;
  localparam int JOY_U  = 3;
  localparam int JOY_K1 = 4;
  localparam int JOY_K2 = 5;
  localparam int JOY_K3 = 6;
  localparam int JOY_K4 = 7;
  localparam int JOY_K5 = 8;
  localparam int JOY_K6 = 9;
  localparam int JOY_W  = 10;

  localparam logic [7:0] CODE_R  = 8'hFD;
  localparam logic [7:0] CODE_L  = 8'hF7;
  localparam logic [7:0] CODE_D  = 8'hFE;
  localparam logic [7:0] CODE_U  = 8'hFB;
  localparam logic [7:0] CODE_RD = 8'hEC;
  localparam logic [7:0] CODE_LD = 8'hE6;
  localparam logic [7:0] CODE_RU = 8'hE9;
  localparam logic [7:0] CODE_LU = 8'hE3;
  localparam logic [7:0] CODE_K1 = 8'hBF;
  localparam logic [7:0] CODE_K2 = 8'h7B;
  localparam logic [7:0] CODE_K3 = 8'h5F;
  localparam logic [7:0] CODE_K4 = 8'hDF;
  localparam logic [7:0] CODE_K5 = 8'h7D;
  localparam logic [7:0] CODE_K6 = 8'h7E;

  // dir is {U,D,L,R}; opposing directions cancel before the codes are combined
  function automatic logic [7:0] pad_encode(input logic [3:0] dir, input logic [5:0] btn);
    logic r, l, d, u;
    logic [7:0] code;
    r = dir[0] & ~dir[1];
    l = dir[1] & ~dir[0];
    d = dir[2] & ~dir[3];
    u = dir[3] & ~dir[2];
    code = 8'hFF;
    if (r) code &= CODE_R;
    if (l) code &= CODE_L;
    if (d) code &= CODE_D;
    if (u) code &= CODE_U;
    if (r && d) code &= CODE_RD;
    if (l && d) code &= CODE_LD;
    if (r && u) code &= CODE_RU;
    if (l && u) code &= CODE_LU;
    if (btn[0]) code &= CODE_K1;
    if (btn[1]) code &= CODE_K2;
    if (btn[2]) code &= CODE_K3;
    if (btn[3]) code &= CODE_K4;
    if (btn[4]) code &= CODE_K5;
    if (btn[5]) code &= CODE_K6;
    return code;
  endfunction

endpackage

// File: rtl/aquarius_pad_ctrl_debounce.sv
// rtl/aquarius_pad_ctrl_debounce.sv - per-bit tick-sampled debouncer for one pad
module pad_debounce
  import aquarius_pad_pkg::*;
#(
  parameter int W           = JOY_W,
  parameter int DEB_SAMPLES = 4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         tick,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam int CW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

  logic [CW-1:0] cnt [W];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < W; i++) begin
        if (d[i] != q[i]) begin
          if (cnt[i] == CNT_LAST) begin
            q[i]   <= d[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/aquarius_pad_ctrl.sv
// rtl/aquarius_pad_ctrl.sv - multi-pad Aquarius controller front end (sync, debounce, turbo, SOCD, encode)
module aquarius_pad_ctrl
  import aquarius_pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int TICK_DIV    = 3580,
  parameter int DEB_SAMPLES = 4,
  parameter int TURBO_TICKS = 50
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [JOY_W*NUM_PADS-1:0] joy_in,
  input  logic [6*NUM_PADS-1:0]     turbo_en,
  output logic [8*NUM_PADS-1:0]     pad_out,
  output logic [NUM_PADS-1:0]       pad_chg,
  output logic                      tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TURBO_TICKS > 1) ? $clog2(TURBO_TICKS) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TB_LAST = TW'(TURBO_TICKS - 1);

  logic [JOY_W*NUM_PADS-1:0] sync1, sync2, acc;
  logic [PW-1:0]             ps_cnt;
  logic [TW-1:0]             tb_cnt;
  logic                      phase;
  logic                      tick_int, tick_d;

  assign tick_int = (ps_cnt == PS_LAST);
  assign tick     = tick_int & reset_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      ps_cnt <= '0;
      tb_cnt <= '0;
      phase  <= 1'b0;
      tick_d <= 1'b0;
    end else begin
      sync1  <= joy_in;
      sync2  <= sync1;
      tick_d <= tick_int;
      ps_cnt <= tick_int ? '0 : ps_cnt + 1'b1;
      // phase 0 is the firing half of the autofire period
      if (tick_int) begin
        if (tb_cnt == TB_LAST) begin
          tb_cnt <= '0;
          phase  <= ~phase;
        end else begin
          tb_cnt <= tb_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [5:0] btn_eff;
    logic [7:0] code;

    pad_debounce #(
      .W          (JOY_W),
      .DEB_SAMPLES(DEB_SAMPLES)
    ) u_deb (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .tick   (tick_int),
      .d      (sync2[p*JOY_W +: JOY_W]),
      .q      (acc[p*JOY_W +: JOY_W])
    );

    always_comb begin
      btn_eff = acc[p*JOY_W+JOY_K1 +: 6] & (~turbo_en[p*6 +: 6] | {6{~phase}});
      code    = pad_encode(acc[p*JOY_W+JOY_R +: 4], btn_eff);
    end

    // the encode is loaded one cycle after the tick so it sees the freshly accepted state
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        pad_out[p*8 +: 8] <= 8'hFF;
        pad_chg[p]        <= 1'b0;
      end else if (tick_d) begin
        pad_out[p*8 +: 8] <= code;
        pad_chg[p]        <= (code != pad_out[p*8 +: 8]);
      end else begin
        pad_chg[p]        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aquarius_pad_ctrl.sv
// tb/tb_aquarius_pad_ctrl.sv - directed self-checking bench for aquarius_pad_ctrl
module tb_aquarius_pad_ctrl;

  localparam logic [9:0] B_R  = 10'h001;
  localparam logic [9:0] B_L  = 10'h002;
  localparam logic [9:0] B_D  = 10'h004;
  localparam logic [9:0] B_U  = 10'h008;
  localparam logic [9:0] B_K1 = 10'h010;
  localparam logic [9:0] B_K2 = 10'h020;
  localparam logic [9:0] B_K6 = 10'h200;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] joy_in  = '0;
  logic [11:0] turbo_en = '0;
  logic [15:0] pad_out;
  logic [1:0]  pad_chg;
  logic        tick;

  int cyc;
  int vectors = 0;
  int miscompares = 0;

  aquarius_pad_ctrl #(
    .NUM_PADS   (2),
    .TICK_DIV   (4),
    .DEB_SAMPLES(3),
    .TURBO_TICKS(2)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .joy_in  (joy_in),
    .turbo_en(turbo_en),
    .pad_out (pad_out),
    .pad_chg (pad_chg),
    .tick    (tick)
  );

  always #5 clk_sys = ~clk_sys;

  // reference cycle count since reset release; a tick falls on every 4th cycle
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(negedge clk_sys); while (cyc % 4 != 3);
    check("tick_strobe", 16'(tick), 16'h0001);
  endtask

  task automatic settle(input logic [19:0] v);
    wait_tick();
    joy_in = v;
    repeat (3) wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev, exp;
    int nt;

    repeat (3) @(negedge clk_sys);
    check("reset_out", pad_out, 16'hFFFF);
    check("reset_chg", 16'(pad_chg), 16'h0000);
    check("reset_tick", 16'(tick), 16'h0000);
    reset_n = 1'b1;

    settle({10'h000, B_R | B_D});
    check("rd_out", pad_out, 16'hFFEC);
    check("rd_chg", 16'(pad_chg), 16'h0001);
    @(negedge clk_sys);
    check("rd_chg_end", 16'(pad_chg), 16'h0000);
    check("tick_low", 16'(tick), 16'h0000);

    reset_n = 1'b0;
    #1;
    check("midrst_out", pad_out, 16'hFFFF);
    check("midrst_chg", 16'(pad_chg), 16'h0000);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("midrst_hold", pad_out, 16'hFFFF);
    wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("midrst_redeb", pad_out, 16'hFFEC);
    check("midrst_chg2", 16'(pad_chg), 16'h0001);

    settle(20'h0);
    check("release_out", pad_out, 16'hFFFF);
    check("release_chg", 16'(pad_chg), 16'h0001);

    wait_tick();
    joy_in = {10'h000, B_K1};
    repeat (2) wait_tick();
    joy_in = '0;
    repeat (3) wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("glitch_out", pad_out, 16'hFFFF);
    check("glitch_chg", 16'(pad_chg), 16'h0000);

    settle({10'h000, B_K1});
    check("k1_out", pad_out, 16'hFFBF);
    check("k1_chg", 16'(pad_chg), 16'h0001);
    settle({10'h000, B_K1 | B_K6});
    check("k1k6_out", pad_out, 16'hFF3E);

    settle({B_L | B_R | B_U, B_K1 | B_K6});
    check("socd_lr_out", pad_out, 16'hFB3E);
    check("socd_lr_chg", 16'(pad_chg), 16'h0002);
    settle({B_U | B_D | B_K2, B_K1 | B_K6});
    check("socd_ud_out", pad_out, 16'h7B3E);
    check("socd_ud_chg", 16'(pad_chg), 16'h0002);

    settle({B_U | B_D | B_K2, B_K1});
    check("pre_turbo", pad_out, 16'h7BBF);
    turbo_en = 12'h001;
    prev = 8'hBF;
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      @(negedge clk_sys);
      @(negedge clk_sys);
      nt  = cyc / 4;
      exp = (((nt / 2) % 2) == 1) ? 8'hFF : 8'hBF;
      check("turbo_out", pad_out, {8'h7B, exp});
      check("turbo_chg", 16'(pad_chg), (exp != prev) ? 16'h0001 : 16'h0000);
      prev = exp;
    end
    turbo_en = '0;

    settle({B_U | B_D | B_K2, B_R});
    check("r_out", pad_out, 16'h7BFD);
    wait_tick();
    joy_in[9:0] = '0;
    repeat (2) wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("r_window", pad_out, 16'h7BFD);
    wait_tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("r_release", pad_out, 16'h7BFF);
    check("r_release_chg", 16'(pad_chg), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
